// File: rtl/avl_text_console_master.sv
// Avalon-MM master writing a character stream into an 80x30 two-glyphs-per-word text VRAM.
// Define TEXT_CONSOLE_SCROLL_EN to scroll at end of screen instead of wrapping to (0,0).
module avl_text_console_master #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [11:0] VRAM_BASE = 12'h000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  input  logic [7:0]  CHAR_DATA,
  input  logic [7:0]  CHAR_ATTR,
  output logic [11:0] AVM_ADDR,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST,
  input  logic        AVM_READDATAVALID,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);
  localparam int          HALF    = COLS / 2;
  localparam int          WORDS   = ROWS * COLS / 2;
  localparam logic [11:0] LAST_A  = VRAM_BASE + 12'(WORDS - 1);
  localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);

`ifdef TEXT_CONSOLE_SCROLL_EN
  typedef enum logic [2:0] {IDLE, WR_CHAR, CLEAR, SCR_RD, SCR_WAIT, SCR_WR, SCR_CLR} state_t;
  localparam logic [11:0] LAST_ROW_A = VRAM_BASE + 12'((ROWS - 1) * HALF);
  logic [11:0] w_q, w_d;
  logic        rd_q, rd_d;
`else
  typedef enum logic [1:0] {IDLE, WR_CHAR, CLEAR} state_t;
  logic unused_rd;
  assign unused_rd = ^{AVM_READDATA, AVM_READDATAVALID};
`endif

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic [7:0]  attr_q, attr_d;
  logic        rdy_q, rdy_d;
  logic        eos;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    attr_d  = attr_q;
    eos     = 1'b0;
`ifdef TEXT_CONSOLE_SCROLL_EN
    w_d     = w_q;
    rd_d    = rd_q;
`endif
    case (state_q)
      IDLE: if (rdy_q && CHAR_VALID) begin
        attr_d = CHAR_ATTR;
        case (CHAR_DATA)
          8'h0D: col_d = 7'd0;
          8'h0A: begin
            col_d = 7'd0;
            if (row_q == ROW_MAX) eos = 1'b1;
            else row_d = row_q + 5'd1;
          end
          8'h0C: begin
            state_d = CLEAR;
            addr_d  = VRAM_BASE;
            wdata_d = {8'h20, CHAR_ATTR, 8'h20, CHAR_ATTR};
            be_d    = 4'b1111;
            wr_d    = 1'b1;
          end
          default: begin
            state_d = WR_CHAR;
            addr_d  = VRAM_BASE + 12'(row_q) * 12'(HALF) + 12'(col_q >> 1);
            wdata_d = col_q[0] ? {CHAR_DATA, CHAR_ATTR, 16'h0} : {16'h0, CHAR_DATA, CHAR_ATTR};
            be_d    = col_q[0] ? 4'b1100 : 4'b0011;
            wr_d    = 1'b1;
          end
        endcase
      end
      WR_CHAR: if (!AVM_WAITREQUEST) begin
        wr_d    = 1'b0;
        state_d = IDLE;
        if (col_q == COL_MAX) begin
          col_d = 7'd0;
          if (row_q == ROW_MAX) eos = 1'b1;
          else row_d = row_q + 5'd1;
        end else col_d = col_q + 7'd1;
      end
      CLEAR: if (!AVM_WAITREQUEST) begin
        if (addr_q == LAST_A) begin
          wr_d    = 1'b0;
          state_d = IDLE;
          col_d   = 7'd0;
          row_d   = 5'd0;
        end else addr_d = addr_q + 12'd1;
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD: if (!AVM_WAITREQUEST) begin
        rd_d    = 1'b0;
        state_d = SCR_WAIT;
      end
      SCR_WAIT: if (AVM_READDATAVALID) begin
        wdata_d = AVM_READDATA;
        addr_d  = VRAM_BASE + w_q - 12'(HALF);
        be_d    = 4'b1111;
        wr_d    = 1'b1;
        state_d = SCR_WR;
      end
      SCR_WR: if (!AVM_WAITREQUEST) begin
        wr_d = 1'b0;
        if (w_q == 12'(WORDS - 1)) begin
          state_d = SCR_CLR;
          addr_d  = LAST_ROW_A;
          wdata_d = {8'h20, attr_q, 8'h20, attr_q};
          wr_d    = 1'b1;
        end else begin
          w_d     = w_q + 12'd1;
          addr_d  = VRAM_BASE + w_q + 12'd1;
          rd_d    = 1'b1;
          state_d = SCR_RD;
        end
      end
      SCR_CLR: if (!AVM_WAITREQUEST) begin
        if (addr_q == LAST_A) begin
          wr_d    = 1'b0;
          state_d = IDLE;
          col_d   = 7'd0;
          row_d   = ROW_MAX;
        end else addr_d = addr_q + 12'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Bottom-right overflow, from either a glyph write or a line feed.
    if (eos) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
      state_d = SCR_RD;
      w_d     = 12'(HALF);
      addr_d  = VRAM_BASE + 12'(HALF);
      rd_d    = 1'b1;
      wr_d    = 1'b0;
`else
      col_d   = 7'd0;
      row_d   = 5'd0;
`endif
    end
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      attr_q  <= '0;
      rdy_q   <= 1'b0;
`ifdef TEXT_CONSOLE_SCROLL_EN
      w_q     <= '0;
      rd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      attr_q  <= attr_d;
      rdy_q   <= rdy_d;
`ifdef TEXT_CONSOLE_SCROLL_EN
      w_q     <= w_d;
      rd_q    <= rd_d;
`endif
    end
  end

  assign CHAR_READY    = rdy_q;
  assign AVM_ADDR      = addr_q;
  assign AVM_WRITE     = wr_q;
  assign AVM_BYTE_EN   = be_q;
  assign AVM_WRITEDATA = wdata_q;
  assign CURSOR_COL    = col_q;
  assign CURSOR_ROW    = row_q;
  assign BUSY          = (state_q != IDLE);
`ifdef TEXT_CONSOLE_SCROLL_EN
  assign AVM_READ      = rd_q;
`else
  assign AVM_READ      = 1'b0;
`endif
endmodule
